bka_pipe_adder: RTL and testbench
=================================

# bka_pipe_adder

Parametrised, pipelined Brent-Kung two-operand adder/subtractor with valid/ready handshakes on input and output. It is the streaming successor to the fixed-width combinational Brent-Kung adder. It adds configurable width, a runtime add/subtract mode, carry-in, carry-out and signed-overflow flags, and a configurable number of pipeline register boundaries. It sits in datapaths that need back-pressure-safe arithmetic at clock rates a single-cycle wide adder cannot meet.

## Interface
- WIDTH, 19: operand width in bits; legal range ≥2.
- PIPE, 2: internal register boundaries, legal range 0..3. 0 gives none. 1 registers after the up-sweep. 2 also registers after P/G generation. 3 also registers mid down-sweep. An output register is always present.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- x  in  WIDTH  operand 1.
- y  in  WIDTH  operand 2.
- cin  in  1  carry-in; in subtract mode, ORed into the implicit +1 path as specified below.
- sub  in  1  0: x+y+cin; 1: x+~y+1 (cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, low WIDTH bits.
- cout  out  1  carry out of bit WIDTH-1. In subtract mode it means "no borrow", i.e. x≥y unsigned.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage function: g=x&y', p=x^y', where y'=sub?~y:y, c0=sub?1:cin.
- Prefix network is Brent-Kung: up-sweep levels at spans 1,2,4,…; down-sweep fills odd/intermediate positions. It is ceil(log2 WIDTH) up-levels plus ceil(log2 WIDTH)-1 down-levels. Ripple or Kogge-Stone substitutes are not permitted.
- Carry i = G[i-1:0] | (P[i-1:0] & c0). sum[i]=p[i]^carry i. cout=carry WIDTH.
- The operator is the standard (G,P)∘(G',P') = (G|P&G', P&P').
- Pipeline advance: global enable adv = ~out_valid | out_ready. in_ready = adv. When adv=1 every stage shifts one slot. A beat enters when in_valid & in_ready.
- Each stage carries a valid bit. Bubbles are not collapsed; a slot with valid=0 still occupies its position.
- With adv=0, all stage registers and outputs hold; sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Per-beat mode: sub and cin are captured with their operands and travel with the beat, so mixed add/sub streams are legal.
- Data registers need no reset; valid bits do.

## Timing
- Latency: PIPE+1 cycles from accepting edge to out_valid=1, with no stall.
- Throughput: one beat per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_valid to out_valid.
- Reset (rst_n=0, asynchronous): all stage valid bits and out_valid go 0 immediately. in_ready reads 1 during and after reset. sum/cout/ovf are 0 after reset.
- Reset mid-operation: in-flight beats are discarded and no partial result is emitted. The first beat after deassertion sees full latency.
- Simultaneous accept and emit with a full pipeline and out_ready=1: both occur in the same cycle with no bubble inserted.
- Full stall: out_valid=1 and out_ready=0 forces in_ready=0. Upstream must hold x/y/sub/cin stable with in_valid; the block holds no skid buffer.
- WIDTH not a power of two: the prefix tree is built over WIDTH positions only. Missing right-hand nodes pass through unchanged.

## Test plan
- WIDTH=19, PIPE=2, add: x=0x7FFFF, y=0x00001, cin=0 → after 3 cycles sum=0x00000, cout=1, ovf=0.
- Signed overflow: x=0x3FFFF, y=0x00001, sub=0 → sum=0x40000, cout=0, ovf=1. Then x=0x3FFFF, y=0x3FFFF, cin=1 → sum=0x7FFFF, cout=0, ovf=1.
- Subtract: x=5, y=7, sub=1 → sum=0x7FFFE, cout=0, ovf=0. Then x=7, y=5, sub=1 → sum=0x00002, cout=1, ovf=0. Check that cin=1 is ignored.
- Back-pressure: stream 8 beats x=i, y=i (i=0..7) with out_ready low for cycles 4–6. Outputs must be 0,2,…,14 in order, with none lost or duplicated, and sum held constant while stalled.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 beats in flight → out_valid drops the same instant, and no stale beat appears after release. The next beat x=1, y=1 gives sum=2 after PIPE+1 cycles.
- Random sweep over PIPE∈{0,1,2,3}, WIDTH∈{2,19,32,64} with random valid/ready: compare against the behavioral {cout,sum}=x+(sub?~y:y)+(sub?1:cin) and check ovf.

Source files
------------

// File: rtl/bka_pipe_adder.sv
// Streaming Brent-Kung adder/subtractor with valid/ready handshakes and a
// configurable number of internal register boundaries in front of the output register.
module bka_pipe_adder #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LOGW = $clog2(WIDTH);
  localparam int unsigned NLEV = 2 * LOGW - 1;
  localparam int unsigned MID  = LOGW + (LOGW - 1) / 2;
  // Beat payload: {c0, bit p, group P, group G}
  localparam int unsigned PW   = 3 * WIDTH + 1;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] yp;
  logic [WIDTH-1:0] pg_p;
  logic [WIDTH-1:0] pg_g;
  logic             pg_c0;

  // Bit-level P/G; the carry-in is folded into position 0 so G alone yields every carry
  always_comb begin
    yp      = sub ? ~y : y;
    pg_c0   = sub | cin;
    pg_p    = x ^ yp;
    pg_g    = x & yp;
    pg_g[0] = pg_g[0] | (pg_p[0] & pg_c0);
  end

  for (genvar n = 0; n <= NLEV; n++) begin : bnd
    localparam int unsigned NREG = ((n == 0 && PIPE >= 2) ? 1 : 0)
                                 + ((n == LOGW && PIPE >= 1) ? 1 : 0)
                                 + ((n == MID && PIPE >= 3) ? 1 : 0);
    logic [PW-1:0] d0;
    logic [PW-1:0] dout;
    logic          v0;
    logic          vout;

    if (n == 0) begin : src
      assign d0 = {pg_c0, pg_p, pg_p, pg_g};
      assign v0 = in_valid;
    end else begin : lvl
      // Levels 0..LOGW-1 are the up-sweep, the rest the down-sweep with shrinking spans
      localparam int unsigned M    = n - 1;
      localparam bit          UP   = (M < LOGW);
      localparam int unsigned SPAN = UP ? (1 << M) : (1 << (2 * LOGW - 2 - M));
      logic [WIDTH-1:0] gl;
      logic [WIDTH-1:0] pl;
      logic [WIDTH-1:0] go;
      logic [WIDTH-1:0] po;
      assign gl = bnd[n-1].dout[WIDTH-1:0];
      assign pl = bnd[n-1].dout[2*WIDTH-1:WIDTH];
      for (genvar i = 0; i < WIDTH; i++) begin : node
        localparam bit HIT = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
        if (HIT) begin : op
          assign go[i] = gl[i] | (pl[i] & gl[i-SPAN]);
          assign po[i] = pl[i] & pl[i-SPAN];
        end else begin : thru
          assign go[i] = gl[i];
          assign po[i] = pl[i];
        end
      end
      assign d0 = {bnd[n-1].dout[PW-1:2*WIDTH], po, go};
      assign v0 = bnd[n-1].vout;
    end

    if (NREG == 0) begin : comb
      assign dout = d0;
      assign vout = v0;
    end else begin : stg
      logic [PW-1:0] r1;
      logic          v1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v1 <= 1'b0;
        else if (adv) v1 <= v0;
      end
      always_ff @(posedge clk) begin
        if (adv) r1 <= d0;
      end
      if (NREG == 1) begin : one
        assign dout = r1;
        assign vout = v1;
      end else begin : two
        // Only tiny widths stack two boundaries at the same tree position
        logic [PW-1:0] r2;
        logic          v2;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)   v2 <= 1'b0;
          else if (adv) v2 <= v1;
        end
        always_ff @(posedge clk) begin
          if (adv) r2 <= r1;
        end
        assign dout = r2;
        assign vout = v2;
      end
    end
  end

  logic [PW-1:0]    fin;
  logic             fin_v;
  logic [WIDTH-1:0] fin_p;
  logic [WIDTH:0]   carry;
  logic             unused_gp;

  assign fin       = bnd[NLEV].dout;
  assign fin_v     = bnd[NLEV].vout;
  assign fin_p     = fin[3*WIDTH-1:2*WIDTH];
  assign carry     = {fin[WIDTH-1:0], fin[PW-1]};
  assign unused_gp = ^fin[2*WIDTH-1:WIDTH];

  // Output register; holds while the downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_v;
      sum       <= fin_p ^ carry[WIDTH-1:0];
      cout      <= carry[WIDTH];
      ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_bka_pipe_adder.sv
// Scoreboard bench for bka_pipe_adder: directed vectors, back-pressure, mid-stream
// reset and a random valid/ready stream checked against a behavioural sum.
module tb_bka_pipe_adder;

  localparam int unsigned WIDTH = 19;
  localparam int unsigned PIPE  = 2;
  localparam int unsigned W1    = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  bka_pipe_adder #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   r;
    exp_t             e;
    bb  = s ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + W1'(s | c);
    e.s = r[WIDTH-1:0];
    e.c = r[WIDTH];
    e.o = (a[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Monitor: pops on every output handshake and checks stability across stalls
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_c = 1'b0;
  logic             held_o = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_sum", 32'(sum), 32'(held_sum));
        check("stall_flags", 32'({cout, ovf}), 32'({held_c, held_o}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got sum 0x%0h expected no beat at cycle %0d", sum, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(mon_e.s));
          check("cout", 32'(cout), 32'(mon_e.c));
          check("ovf", 32'(ovf), 32'(mon_e.o));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_sum   = sum;
      held_c     = cout;
      held_o     = ovf;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                      input logic cv, input logic sv,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                      output int acc_cyc);
    bit acc = 1'b0;
    int tries = 0;
    acc_cyc = -1;
    in_valid = 1'b1;
    x = xv;
    y = yv;
    cin = cv;
    sub = sv;
    while (!acc && tries < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back('{es, ec, eo});
      end
      tries++;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  // One beat into an idle pipe, also measuring latency
  task automatic single(input string nm, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                        input logic cv, input logic sv,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int a;
    int lat = -1;
    send(xv, yv, cv, sv, es, ec, eo, a);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - a;
        break;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'(PIPE + 1));
    drain();
  endtask

  initial begin
    int   a;
    exp_t e;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic cr;
    logic sr;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_flags", 32'({cout, ovf}), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single("wrap_add",   19'h7FFFF, 19'h00001, 1'b0, 1'b0, 19'h00000, 1'b1, 1'b0);
    single("ovf_add",    19'h3FFFF, 19'h00001, 1'b0, 1'b0, 19'h40000, 1'b0, 1'b1);
    single("ovf_cin",    19'h3FFFF, 19'h3FFFF, 1'b1, 1'b0, 19'h7FFFF, 1'b0, 1'b1);
    single("sub_borrow", 19'h00005, 19'h00007, 1'b0, 1'b1, 19'h7FFFE, 1'b0, 1'b0);
    single("sub_pos",    19'h00007, 19'h00005, 1'b0, 1'b1, 19'h00002, 1'b1, 1'b0);
    single("sub_cin_ign",19'h00007, 19'h00005, 1'b1, 1'b1, 19'h00002, 1'b1, 1'b0);
    single("sub_zero",   19'h00000, 19'h00000, 1'b0, 1'b1, 19'h00000, 1'b1, 1'b0);
    single("sub_ovf",    19'h40000, 19'h00001, 1'b0, 1'b1, 19'h3FFFF, 1'b1, 1'b1);
    single("all_ones",   19'h7FFFF, 19'h7FFFF, 1'b1, 1'b0, 19'h7FFFF, 1'b1, 1'b0);
    single("long_carry", 19'h55555, 19'h2AAAA, 1'b1, 1'b0, 19'h00000, 1'b1, 1'b0);

    // Back-pressure: eight beats with the sink stalled for three cycles
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, WIDTH'(2 * i), 1'b0, 1'b0, a);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(WIDTH'(10 + i), WIDTH'(10), 1'b0, 1'b0, WIDTH'(20 + i), 1'b0, 1'b0, a);
    #2;
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_sum", 32'(sum), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    single("post_reset", 19'h00001, 19'h00001, 1'b0, 1'b0, 19'h00002, 1'b0, 1'b0);

    // Random mixed add/sub stream with random sink readiness and source gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      xr = WIDTH'($urandom);
      yr = WIDTH'($urandom);
      cr = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      e  = model(xr, yr, cr, sr);
      send(xr, yr, cr, sr, e.s, e.c, e.o, a);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1);
  end

endmodule
